// File: rtl/ipi_histogrammer.sv
// Per-channel hit edge counters plus a histogram of trigger-to-trigger intervals.
// Define IPI_OVERFLOW_BIN_EN to fold out-of-range intervals into the last bin instead of dropping them.
module ipi_histogrammer #(
  parameter int CNT_W     = 16,
  parameter int BIN_SHIFT = 2,
  parameter int NBINS     = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            hit,
  input  logic                  trig,
  input  logic                  resethist,
  output logic [255:0]          h_flat,
  output logic [32*NBINS-1:0]   ipihist_flat,
  output logic                  armed
);

  localparam int IDX_W = CNT_W - BIN_SHIFT;
  localparam int BIN_W = $clog2(NBINS);

  logic [7:0]             hit_q;
  logic                   trig_q;
  logic [7:0][31:0]       h_cnt;
  logic [NBINS-1:0][31:0] ipi_cnt;
  logic [CNT_W-1:0]       interval;
  logic                   bin_vld;
  logic [BIN_W-1:0]       bin_idx;

  logic [7:0]             hit_edge;
  logic                   trig_edge;
  logic [IDX_W-1:0]       raw_idx;
  logic                   in_range;
  logic [BIN_W-1:0]       stage_idx;
  logic                   stage_ok;

  assign hit_edge  = hit & ~hit_q;
  assign trig_edge = trig & ~trig_q;
  assign raw_idx   = interval[CNT_W-1:BIN_SHIFT];
  assign in_range  = (raw_idx < IDX_W'(NBINS));

`ifdef IPI_OVERFLOW_BIN_EN
  // Long intervals, including a saturated counter, land in the top bin.
  assign stage_idx = in_range ? raw_idx[BIN_W-1:0] : BIN_W'(NBINS - 1);
  assign stage_ok  = 1'b1;
`else
  assign stage_idx = raw_idx[BIN_W-1:0];
  assign stage_ok  = in_range;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      trig_q <= 1'b0;
    end else begin
      hit_q  <= hit;
      trig_q <= trig;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
    end else if (resethist) begin
      h_cnt <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (hit_edge[i] && (h_cnt[i] != 32'hFFFF_FFFF)) begin
          h_cnt[i] <= h_cnt[i] + 32'd1;
        end
      end
    end
  end

  // Stage 1: interval capture and bin selection on the trigger edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      interval <= '0;
      armed    <= 1'b0;
      bin_vld  <= 1'b0;
      bin_idx  <= '0;
    end else if (resethist) begin
      interval <= '0;
      armed    <= 1'b0;
      bin_vld  <= 1'b0;
    end else begin
      if (trig_edge) begin
        interval <= CNT_W'(1);
      end else if (armed && (interval != {CNT_W{1'b1}})) begin
        interval <= interval + CNT_W'(1);
      end
      bin_vld <= trig_edge & armed & stage_ok;
      if (trig_edge) begin
        armed <= 1'b1;
        if (armed) begin
          bin_idx <= stage_idx;
        end
      end
    end
  end

  // Stage 2: bump the selected bin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ipi_cnt <= '0;
    end else if (resethist) begin
      ipi_cnt <= '0;
    end else if (bin_vld && (ipi_cnt[bin_idx] != 32'hFFFF_FFFF)) begin
      ipi_cnt[bin_idx] <= ipi_cnt[bin_idx] + 32'd1;
    end
  end

  assign h_flat       = h_cnt;
  assign ipihist_flat = ipi_cnt;

endmodule

// File: tb/tb_ipi_histogrammer.sv
// Scoreboard bench for ipi_histogrammer: stimulus queues timed expectations, a negedge monitor checks them.
module tb_ipi_histogrammer;

  localparam int K_H   = 0;
  localparam int K_IPI = 1;
  localparam int K_ARM = 2;
  localparam int K_HNZ = 3;
  localparam int K_INZ = 4;
`ifdef IPI_OVERFLOW_BIN_EN
  localparam int OVF_BIN = 63;
`else
  localparam int OVF_BIN = -1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    hit;
  logic          trig;
  logic          resethist;
  logic [255:0]  h_flat;
  logic [2047:0] ipihist_flat;
  logic          armed;

  typedef struct {
    int unsigned due;
    int          kind;
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          exp_ipi[64];
  int unsigned last_edge;
  logic [7:0][31:0] sat_val;

  ipi_histogrammer dut (
    .clk(clk), .rst_n(rst_n), .hit(hit), .trig(trig), .resethist(resethist),
    .h_flat(h_flat), .ipihist_flat(ipihist_flat), .armed(armed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dut_val(input int kind, input int idx);
    int n;
    n = 0;
    case (kind)
      K_H:   return h_flat[32*idx +: 32];
      K_IPI: return ipihist_flat[32*idx +: 32];
      K_ARM: return {31'b0, armed};
      K_HNZ: begin
        for (int i = 0; i < 8; i++) if (h_flat[32*i +: 32] != 0) n++;
        return 32'(n);
      end
      default: begin
        for (int i = 0; i < 64; i++) if (ipihist_flat[32*i +: 32] != 0) n++;
        return 32'(n);
      end
    endcase
  endfunction

  function automatic int ipi_nonzero();
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) if (exp_ipi[i] != 0) n++;
    return n;
  endfunction

  task automatic push_exp(input int unsigned due, input int kind, input int idx,
                          input logic [31:0] val, input string name);
    exp_t e;
    e.due = due; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    int k;
    logic [31:0] got;
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].due == cyc) begin
        got = dut_val(sb[k].kind, sb[k].idx);
        checks++;
        if (got !== sb[k].val) begin
          failures++;
          $display("FAIL %s idx=%0d cyc=%0d: got %0h expected %0h",
                   sb[k].name, sb[k].idx, cyc, got, sb[k].val);
        end
        sb.delete(k);
      end else begin
        k++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Drives a trigger rising edge gap cycles after the previous one; bin < 0 means no bin entry.
  task automatic trig_edge(input int unsigned gap, input int bin);
    int guard;
    guard = 0;
    while ((cyc < last_edge + gap) && (guard < 2000)) begin
      step();
      guard++;
    end
    trig = 1'b1;
    last_edge = cyc;
    if (bin >= 0) begin
      exp_ipi[bin]++;
      push_exp(cyc + 1, K_IPI, bin, 32'(exp_ipi[bin] - 1), "ipi_before");
      push_exp(cyc + 2, K_IPI, bin, 32'(exp_ipi[bin]), "ipi_bin");
    end
    push_exp(cyc + 1, K_ARM, 0, 32'd1, "armed_set");
    push_exp(cyc + 2, K_INZ, 0, 32'(ipi_nonzero()), "ipi_nonzero");
    step();
    trig = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (exp_ipi[i]) exp_ipi[i] = 0;
    rst_n = 1'b0; hit = '0; trig = 1'b0; resethist = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    push_exp(cyc + 1, K_ARM, 0, 32'd0, "rst_armed");
    push_exp(cyc + 1, K_HNZ, 0, 32'd0, "rst_h");
    push_exp(cyc + 1, K_INZ, 0, 32'd0, "rst_ipi");
    step();

    // Four 3-cycle pulses of 8'h05.
    for (int p = 0; p < 4; p++) begin
      hit = 8'h05;
      push_exp(cyc + 1, K_H, 0, 32'(p + 1), "h0_count");
      push_exp(cyc + 1, K_H, 2, 32'(p + 1), "h2_count");
      repeat (3) step();
      hit = 8'h00;
      repeat (2) step();
    end
    push_exp(cyc + 1, K_H, 0, 32'd4, "h0_final");
    push_exp(cyc + 1, K_H, 2, 32'd4, "h2_final");
    push_exp(cyc + 1, K_HNZ, 0, 32'd2, "h_nonzero");
    push_exp(cyc + 1, K_INZ, 0, 32'd0, "ipi_still_zero");
    push_exp(cyc + 1, K_ARM, 0, 32'd0, "not_armed");
    repeat (4) step();

    // Interval histogram: arm, 20 (bin 5) twice, 252 (bin 63), 300, then 2 twice (bin 0).
    last_edge = cyc;
    trig_edge(2, -1);
    trig_edge(20, 5);
    trig_edge(20, 5);
    trig_edge(252, 63);
    trig_edge(300, OVF_BIN);
    trig_edge(2, 0);
    trig_edge(2, 0);
    repeat (4) step();

    // Clear coinciding with a new trigger edge while hit[7] is held.
    hit = 8'h80;
    push_exp(cyc + 1, K_H, 7, 32'd1, "h7_edge");
    repeat (10) step();
    trig = 1'b1; resethist = 1'b1;
    foreach (exp_ipi[i]) exp_ipi[i] = 0;
    push_exp(cyc + 1, K_HNZ, 0, 32'd0, "clr_h");
    push_exp(cyc + 1, K_INZ, 0, 32'd0, "clr_ipi");
    push_exp(cyc + 1, K_ARM, 0, 32'd0, "clr_armed");
    repeat (3) step();
    resethist = 1'b0;
    push_exp(cyc + 2, K_H, 7, 32'd0, "h7_held_level");
    push_exp(cyc + 2, K_ARM, 0, 32'd0, "trig_held_level");
    repeat (3) step();
    trig = 1'b0; hit = 8'h00;
    repeat (2) step();
    last_edge = cyc;
    trig_edge(2, -1);
    // A pending stage-2 increment is dropped by a clear in the next cycle.
    repeat (19) step();
    trig = 1'b1;
    step();
    trig = 1'b0; resethist = 1'b1;
    push_exp(cyc + 1, K_INZ, 0, 32'd0, "drop_pending");
    push_exp(cyc + 1, K_ARM, 0, 32'd0, "drop_armed");
    push_exp(cyc + 2, K_INZ, 0, 32'd0, "drop_pending_late");
    step();
    resethist = 1'b0;
    repeat (3) step();

    // Channel counter saturation.
    sat_val = '0;
    sat_val[3] = 32'hFFFF_FFFE;
    force dut.h_cnt = sat_val;
    step();
    release dut.h_cnt;
    push_exp(cyc + 1, K_H, 3, 32'hFFFF_FFFE, "h3_preload");
    step();
    for (int p = 0; p < 3; p++) begin
      hit = 8'h08;
      push_exp(cyc + 1, K_H, 3, 32'hFFFF_FFFF, "h3_saturate");
      step();
      hit = 8'h00;
      step();
    end
    push_exp(cyc + 1, K_HNZ, 0, 32'd1, "h_only_ch3");
    step();

    // Asynchronous reset with a bin increment in flight.
    last_edge = cyc;
    trig_edge(2, -1);
    repeat (19) step();
    trig = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    push_exp(cyc, K_HNZ, 0, 32'd0, "arst_h");
    push_exp(cyc, K_INZ, 0, 32'd0, "arst_ipi");
    push_exp(cyc, K_ARM, 0, 32'd0, "arst_armed");
    trig = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    push_exp(cyc + 1, K_INZ, 0, 32'd0, "arst_no_inc");
    push_exp(cyc + 3, K_INZ, 0, 32'd0, "arst_no_inc_late");
    push_exp(cyc + 3, K_ARM, 0, 32'd0, "arst_armed_late");
    repeat (5) step();

    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      failures += sb.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
